// File: rtl/tick_sched_ctrl.sv
`timescale 1ns/1ps
// tick_sched_ctrl: run-time controller for the board timebase.
// A programmable period counter produces a one-cycle tick strobe at the end of
// every period plus a 50% square wave derived from it. Start/stop/burst
// sequencing is handled by a small three-state FSM. New divisor/burst settings
// arrive over a valid/ready handshake. While running they are parked in a
// pending register and applied only at a period boundary, so downstream
// consumers never see a runt period.
module tick_sched_ctrl #(
    parameter int unsigned         CNT_W       = 32,
    parameter logic [CNT_W-1:0]    DEFAULT_DIV = 50000000,
    parameter int unsigned         BURST_W     = 8
) (
    input  logic               top_clk,
    input  logic               top_rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               tick,
    output logic               clock_out,
    output logic               done,
    output logic               busy,
    output logic [BURST_W-1:0] remaining,
    output logic [1:0]         state
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] REM_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    // Control state
    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   active_div_q;
    logic [BURST_W-1:0] active_burst_q;
    logic [BURST_W-1:0] remaining_q;
    logic               clock_out_q;
    logic               pend_vld_q;

    // Pending configuration payload; only meaningful while pend_vld_q is set
    logic [CNT_W-1:0]   pend_div_q;
    logic [BURST_W-1:0] pend_burst_q;

    // Decoded events for the current cycle
    logic running;
    logic wrap;
    logic xfer;
    logic apply_pend;
    logic burst_mode;
    logic burst_last;
    logic finish_wrap;
    logic end_run;

    // Per-cycle event decode. A wrap that applies a pending config restarts
    // the burst under the new settings, so it never counts as the last tick
    // of the old burst.
    always_comb begin
        running     = (state_q != ST_IDLE);
        wrap        = running && (cnt_q == active_div_q);
        xfer        = cfg_valid && !pend_vld_q;
        apply_pend  = wrap && pend_vld_q;
        burst_mode  = (active_burst_q != '0);
        burst_last  = wrap && (state_q == ST_RUN) && !apply_pend &&
                      burst_mode && (remaining_q == REM_ONE);
        finish_wrap = wrap && (state_q == ST_FINISH);
        end_run     = burst_last || finish_wrap;
    end

    // Next-state logic: stop wins over start in IDLE; a burst ending on the
    // same wrap as a stop request takes precedence and returns straight to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (burst_last) begin
                    state_d = ST_IDLE;
                end else if (stop) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Period counter: held at zero in IDLE, counts 0..active_div while busy.
    // Entering FINISH does not disturb it, so the current period completes.
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            cnt_q <= '0;
        end else if (!running || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // Active configuration: loads directly when idle, otherwise only from the
    // pending register at a period boundary.
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            active_div_q   <= DEFAULT_DIV;
            active_burst_q <= '0;
        end else if (!running && xfer) begin
            active_div_q   <= cfg_div;
            active_burst_q <= cfg_burst;
        end else if (apply_pend) begin
            active_div_q   <= pend_div_q;
            active_burst_q <= pend_burst_q;
        end
    end

    // Pending flag: set by a transfer while busy, cleared when applied. A
    // transfer on a wrap cycle cannot be applied on that same wrap because the
    // flag was still clear when the wrap was decoded.
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            pend_vld_q <= 1'b0;
        end else if (apply_pend) begin
            pend_vld_q <= 1'b0;
        end else if (running && xfer) begin
            pend_vld_q <= 1'b1;
        end
    end

    // Pending payload capture; cfg_div/cfg_burst are sampled only on transfer
    always_ff @(posedge top_clk) begin
        if (running && xfer) begin
            pend_div_q   <= cfg_div;
            pend_burst_q <= cfg_burst;
        end
    end

    // Remaining-tick counter: loads on start, reloads on a config apply,
    // decrements at each wrap in burst mode and clears when the run ends.
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            remaining_q <= '0;
        end else if (!running) begin
            if (state_d == ST_RUN) begin
                remaining_q <= active_burst_q;
            end
        end else if (end_run) begin
            remaining_q <= '0;
        end else if (apply_pend) begin
            remaining_q <= pend_burst_q;
        end else if (wrap && burst_mode) begin
            remaining_q <= remaining_q - REM_ONE;
        end
    end

    // Square wave: toggles with every tick, parked low whenever idle or ending
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            clock_out_q <= 1'b0;
        end else if (!running || end_run) begin
            clock_out_q <= 1'b0;
        end else if (wrap) begin
            clock_out_q <= ~clock_out_q;
        end
    end

    // Output mapping: tick and done are pure decodes of the wrap cycle
    always_comb begin
        tick      = wrap;
        done      = end_run;
        busy      = running;
        cfg_ready = !pend_vld_q;
        clock_out = clock_out_q;
        remaining = remaining_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
`timescale 1ns/1ps
// Directed bench for tick_sched_ctrl: a vector table for the single-cycle
// behaviour plus hand-written sequences for reset, stop, reconfig and
// wrap-cycle collisions. Outputs are sampled on the falling edge.
module tb_tick_sched_ctrl;

    localparam int CNT_W   = 32;
    localparam int BURST_W = 8;
    localparam int DEF_DIV = 5;

    logic               top_clk = 1'b0;
    logic               top_rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [CNT_W-1:0]   cfg_div = '0;
    logic [BURST_W-1:0] cfg_burst = '0;
    logic               cfg_ready;
    logic               tick;
    logic               clock_out;
    logic               done;
    logic               busy;
    logic [BURST_W-1:0] remaining;
    logic [1:0]         state;

    int n_checks = 0;
    int n_pass   = 0;

    tick_sched_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF_DIV),
        .BURST_W    (BURST_W)
    ) dut (
        .top_clk  (top_clk),
        .top_rst_n(top_rst_n),
        .start    (start),
        .stop     (stop),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_burst(cfg_burst),
        .tick     (tick),
        .clock_out(clock_out),
        .done     (done),
        .busy     (busy),
        .remaining(remaining),
        .state    (state)
    );

    always #5 top_clk = ~top_clk;

    typedef struct {
        logic               st;
        logic               sp;
        logic               cv;
        logic [CNT_W-1:0]   div;
        logic [BURST_W-1:0] burst;
        logic               e_tick;
        logic               e_co;
        logic               e_done;
        logic               e_busy;
        logic [BURST_W-1:0] e_rem;
        logic [1:0]         e_state;
        logic               e_rdy;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic st, input logic sp, input logic cv,
                                input logic [CNT_W-1:0] d, input logic [BURST_W-1:0] b,
                                input logic t, input logic co, input logic dn, input logic bz,
                                input logic [BURST_W-1:0] r, input logic [1:0] s, input logic rdy);
        vec_t v;
        v.st = st; v.sp = sp; v.cv = cv; v.div = d; v.burst = b;
        v.e_tick = t; v.e_co = co; v.e_done = dn; v.e_busy = bz;
        v.e_rem = r; v.e_state = s; v.e_rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic t, input logic co, input logic dn,
                           input logic bz, input logic [BURST_W-1:0] r, input logic [1:0] s,
                           input logic rdy);
        chk({tag, ".tick"},      32'(tick),      32'(t));
        chk({tag, ".clock_out"}, 32'(clock_out), 32'(co));
        chk({tag, ".done"},      32'(done),      32'(dn));
        chk({tag, ".busy"},      32'(busy),      32'(bz));
        chk({tag, ".remaining"}, 32'(remaining), 32'(r));
        chk({tag, ".state"},     32'(state),     32'(s));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(rdy));
    endtask

    task automatic cyc();
        @(negedge top_clk);
    endtask

    // Advance until tick is seen; n = cycles advanced
    task automatic wait_tick(input string name, input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (tick !== 1'b1 && n < budget);
        if (tick !== 1'b1) begin
            n_checks++;
            $display("FAIL %s: no tick within %0d cycles", name, budget);
        end
    endtask

    task automatic load_cfg(input logic [CNT_W-1:0] d, input logic [BURST_W-1:0] b);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_burst = b;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ticks;
        logic exp_co;

        // Burst of 3 at div=2, start/stop collision, stop alone, div=0 with a stop
        vt[0]  = mk(0,0,1, 2,3, 0,0,0,0, 0,2'd0,1);
        vt[1]  = mk(1,0,0, 0,0, 0,0,0,0, 0,2'd0,1);
        vt[2]  = mk(0,0,0, 0,0, 0,0,0,1, 3,2'd1,1);
        vt[3]  = mk(0,0,0, 0,0, 0,0,0,1, 3,2'd1,1);
        vt[4]  = mk(0,0,0, 0,0, 1,0,0,1, 3,2'd1,1);
        vt[5]  = mk(0,0,0, 0,0, 0,1,0,1, 2,2'd1,1);
        vt[6]  = mk(0,0,0, 0,0, 0,1,0,1, 2,2'd1,1);
        vt[7]  = mk(0,0,0, 0,0, 1,1,0,1, 2,2'd1,1);
        vt[8]  = mk(0,0,0, 0,0, 0,0,0,1, 1,2'd1,1);
        vt[9]  = mk(0,0,0, 0,0, 0,0,0,1, 1,2'd1,1);
        vt[10] = mk(0,0,0, 0,0, 1,0,1,1, 1,2'd1,1);
        vt[11] = mk(1,1,0, 0,0, 0,0,0,0, 0,2'd0,1);
        vt[12] = mk(0,1,0, 0,0, 0,0,0,0, 0,2'd0,1);
        vt[13] = mk(0,0,1, 0,0, 0,0,0,0, 0,2'd0,1);
        vt[14] = mk(1,0,0, 0,0, 0,0,0,0, 0,2'd0,1);
        vt[15] = mk(0,0,0, 0,0, 1,0,0,1, 0,2'd1,1);
        vt[16] = mk(0,0,0, 0,0, 1,1,0,1, 0,2'd1,1);
        vt[17] = mk(0,1,0, 0,0, 1,0,0,1, 0,2'd1,1);
        vt[18] = mk(0,0,0, 0,0, 1,1,1,1, 0,2'd2,1);
        vt[19] = mk(0,0,0, 0,0, 0,0,0,0, 0,2'd0,1);

        // Reset state and default divisor
        repeat (2) cyc();
        top_rst_n = 1'b1;
        cyc();
        chk_all("reset", 0,0,0,0, 0,2'd0,1);
        start = 1'b1;
        wait_tick("default_first_tick", 20, n);
        start = 1'b0;
        chk("default_latency", 32'(n), 32'(DEF_DIV + 1));

        // Asynchronous reset in the middle of a run
        repeat (2) cyc();
        #2 top_rst_n = 1'b0;
        #1 chk_all("midrun_reset", 0,0,0,0, 0,2'd0,1);
        cyc();
        top_rst_n = 1'b1;

        // div=3 continuous: tick every 4 cycles, clock_out period 8
        load_cfg(3, 0);
        start = 1'b1;
        wait_tick("div3_first", 20, n);
        start = 1'b0;
        chk("div3_latency", 32'(n), 32'd4);
        wait_tick("div3_second", 20, n);
        chk("div3_period", 32'(n), 32'd4);
        chk("div3_co_at_tick2", 32'(clock_out), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp_co = (k > 4);
            chk($sformatf("div3_co_k%0d", k), 32'(clock_out), 32'(exp_co));
            chk($sformatf("div3_tick_k%0d", k), 32'(tick), 32'((k == 4) || (k == 8)));
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("div3_stop_state", 32'(state), 32'd2);
        wait_tick("div3_finish", 20, n);
        chk("div3_finish_wait", 32'(n), 32'd3);
        chk("div3_finish_done", 32'(done), 32'd1);
        cyc();
        chk_all("div3_idle", 0,0,0,0, 0,2'd0,1);

        // Vector table
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_all($sformatf("vec%0d", i), vt[i].e_tick, vt[i].e_co, vt[i].e_done,
                    vt[i].e_busy, vt[i].e_rem, vt[i].e_state, vt[i].e_rdy);
            start     = vt[i].st;
            stop      = vt[i].sp;
            cfg_valid = vt[i].cv;
            cfg_div   = vt[i].div;
            cfg_burst = vt[i].burst;
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cyc();

        // Graceful stop, div=9, stop 4 cycles after a tick
        load_cfg(9, 0);
        start = 1'b1;
        wait_tick("gs_first", 30, n);
        start = 1'b0;
        chk("gs_latency", 32'(n), 32'd10);
        repeat (4) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("gs_state_finish", 32'(state), 32'd2);
        chk("gs_busy_finish", 32'(busy), 32'd1);
        wait_tick("gs_last", 30, n);
        chk("gs_stop_to_tick", 32'(n + 1), 32'd6);
        chk("gs_done", 32'(done), 32'd1);
        cyc();
        chk_all("gs_idle", 0,0,0,0, 0,2'd0,1);
        ticks = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (tick === 1'b1) ticks++;
        end
        chk("gs_no_more_ticks", 32'(ticks), 32'd0);

        // Live reconfig: div=7 running, offer div=1 mid-period
        load_cfg(7, 0);
        start = 1'b1;
        wait_tick("lr_first", 30, n);
        start = 1'b0;
        chk("lr_latency", 32'(n), 32'd8);
        repeat (3) cyc();
        chk("lr_ready_before", 32'(cfg_ready), 32'd1);
        load_cfg(1, 0);
        chk("lr_ready_drop", 32'(cfg_ready), 32'd0);
        wait_tick("lr_old_period", 30, n);
        chk("lr_old_period", 32'(n + 4), 32'd8);
        chk("lr_ready_at_wrap", 32'(cfg_ready), 32'd0);
        wait_tick("lr_new1", 30, n);
        chk("lr_new_period1", 32'(n), 32'd2);
        chk("lr_ready_after", 32'(cfg_ready), 32'd1);
        wait_tick("lr_new2", 30, n);
        chk("lr_new_period2", 32'(n), 32'd2);

        // Transfer on a wrap cycle: div=1 still used for one more period
        load_cfg(4, 0);
        chk("wc_ready_drop", 32'(cfg_ready), 32'd0);
        wait_tick("wc_old", 30, n);
        chk("wc_old_period", 32'(n + 1), 32'd2);
        wait_tick("wc_new1", 30, n);
        chk("wc_new_period1", 32'(n), 32'd5);
        chk("wc_ready_back", 32'(cfg_ready), 32'd1);
        wait_tick("wc_new2", 30, n);
        chk("wc_new_period2", 32'(n), 32'd5);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_tick("wc_finish", 30, n);
        chk("wc_finish_wait", 32'(n + 1), 32'd5);
        chk("wc_finish_done", 32'(done), 32'd1);
        cyc();
        chk_all("wc_idle", 0,0,0,0, 0,2'd0,1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
Run-time controller for the board timebase. Owns a programmable period counter. Sequences start, stop and burst operation. Accepts new divisor/burst settings through a valid/ready handshake and applies them only at period boundaries, so the LED, seven-segment and debounce logic never see a runt period. Produces a one-cycle enable strobe (tick) plus a 50% square wave (clock_out) for legacy consumers.

Parameters:
CNT_W, 32, width of divisor and period counter
DEFAULT_DIV, 50000000, active divisor after reset; period = DIV+1 cycles
BURST_W, 8, width of burst-length field and remaining-tick counter

Ports:
top_clk  input  1  system clock, all logic on rising edge
top_rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled; begin ticking from IDLE
stop  input  1  level-sampled; request graceful stop
cfg_valid  input  1  config offer
cfg_ready  output  1  config can be accepted this cycle
cfg_div  input  CNT_W  requested divisor
cfg_burst  input  BURST_W  ticks per run; 0 = continuous
tick  output  1  one-cycle strobe at each period end
clock_out  output  1  toggles on every tick (square wave)
done  output  1  one-cycle pulse when returning to IDLE
busy  output  1  high in RUN or FINISH
remaining  output  BURST_W  ticks left in burst; 0 in continuous mode
state  output  2  IDLE=00, RUN=01, FINISH=10

Behaviour:
- Reset (async, top_rst_n=0): state=IDLE, counter=0, active_div=DEFAULT_DIV, active_burst=0, no pending config. Outputs: tick=0, clock_out=0, done=0, busy=0, remaining=0, cfg_ready=1. Reset mid-run aborts immediately; no done pulse.
- Counter: in RUN/FINISH, counts 0..active_div. On count==active_div (the "wrap"), the counter returns to 0 and tick=1 for exactly that cycle; clock_out toggles registered with tick. active_div=0 gives a tick every cycle. Comparison is unsigned, full CNT_W.
- IDLE: counter held at 0, clock_out=0.
  - start=1 and stop=0 -> RUN next cycle; remaining loads active_burst.
  - start=1 with stop=1 -> stay IDLE (stop wins).
  - stop alone is ignored.
- RUN:
  - At wrap in burst mode, remaining decrements. If remaining was 1: go to IDLE, clock_out forced 0, done=1 that cycle.
  - stop=1 -> FINISH; counter is not reset.
  - start is ignored.
- FINISH: counter continues to the wrap. At the wrap: tick=1, clock_out forced 0, done=1, go to IDLE. Further stop is ignored.
- Config handshake: transfer occurs when cfg_valid & cfg_ready.
  - In IDLE: active_div/active_burst load on the next edge; cfg_ready stays 1.
  - In RUN/FINISH: the values go to a pending register and cfg_ready drops to 0. Pending is applied at the next wrap: the counter restarts at 0 under the new div, and remaining reloads with the new burst. cfg_ready returns to 1 the cycle after application.
  - Transfer on the same cycle as a wrap: the new values become pending and apply at the following wrap.
  - If the FINISH wrap applies a pending config, the block still goes to IDLE with the new config active.
  - cfg_div/cfg_burst are sampled only on transfer.
- Latency: start high at edge N -> state=RUN at N+1 -> first tick at edge N+1+active_div+1.
- done and tick are never high outside the wrap cycle. busy = (state != IDLE).

Test Plan:
- Reset defaults: assert top_rst_n=0 mid-RUN -> all outputs 0 immediately, cfg_ready=1, state=00; after release with cfg_div=3, start -> tick every 4 cycles, clock_out period 8 cycles.
- Burst: cfg_div=2, cfg_burst=3, start -> exactly 3 ticks spaced 3 cycles apart, remaining 3→2→1→0, done on the 3rd tick, state=00, clock_out=0.
- Graceful stop: continuous div=9, stop asserted 4 cycles after a tick -> state=10; the next tick comes 6 cycles later with done=1, then IDLE; no further ticks.
- Live reconfig: running div=7, offer cfg_div=1 mid-period -> cfg_ready=0 the next cycle; the current period completes at 8 cycles; subsequent ticks are every 2 cycles; cfg_ready=1 after the apply.
- Collisions: start&stop together in IDLE -> remain IDLE; cfg transfer on a wrap cycle -> old div still used for one more full period.
- div=0 edge case: cfg_div=0, start -> tick=1 every cycle, clock_out toggles every cycle.
